// File: rtl/aib_avmm_rdl_mux_intf.sv
// Avalon-MM slave that steers single accesses onto NUM_CH RDL register banks.
// Reads finish through a bounded wait; decode failures and timeouts return an error completion.
module aib_avmm_rdl_mux_intf #(
  parameter int                    AVMM_ADDR_WIDTH = 12,
  parameter int                    RDL_ADDR_WIDTH  = 8,
  parameter int                    NUM_CH          = 4,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    TIMEOUT_CYC     = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = '1,
  localparam int                   BE_WIDTH        = DATA_WIDTH / 8
) (
  input  logic                         avmm_clk,
  input  logic                         avmm_rst,
  input  logic                         i_avmm_write,
  input  logic                         i_avmm_read,
  input  logic [AVMM_ADDR_WIDTH-1:0]   i_avmm_addr,
  input  logic [DATA_WIDTH-1:0]        i_avmm_wdata,
  input  logic [BE_WIDTH-1:0]          i_avmm_byte_en,
  output logic [DATA_WIDTH-1:0]        o_avmm_rdata,
  output logic                         o_avmm_rdatavalid,
  output logic                         o_avmm_waitrequest,
  output logic                         o_avmm_rsp_err,
  output logic [7:0]                   o_err_cnt,
  output logic                         rdl_clk,
  output logic                         rdl_reset,
  output logic [NUM_CH-1:0]            rdl_write,
  output logic [NUM_CH-1:0]            rdl_read,
  output logic [RDL_ADDR_WIDTH-1:0]    rdl_address,
  output logic [DATA_WIDTH-1:0]        rdl_writedata,
  output logic [BE_WIDTH-1:0]          rdl_byteenable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rdl_readdata,
  input  logic [NUM_CH-1:0]            rdl_readdatavalid
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;
  localparam logic [AVMM_ADDR_WIDTH-1:0] CH_MASK  = AVMM_ADDR_WIDTH'((1 << CH_BITS) - 1);
  localparam logic [CH_W:0]              NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [7:0]                 TMO_LAST = 8'(TIMEOUT_CYC - 1);

  if (AVMM_ADDR_WIDTH < RDL_ADDR_WIDTH + CH_BITS) begin : g_addr_width_chk
    $error("AVMM_ADDR_WIDTH too small for RDL_ADDR_WIDTH plus bank select bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CPL   = 3'd4
  } state_t;

  state_t                    state_r;
  logic [RDL_ADDR_WIDTH-1:0] cmd_addr_r;
  logic [DATA_WIDTH-1:0]     cmd_wdata_r;
  logic [BE_WIDTH-1:0]       cmd_be_r;
  logic [CH_W-1:0]           cmd_bank_r;
  logic                      cmd_oor_r;
  logic [7:0]                tmo_cnt_r;
  logic [7:0]                err_cnt_r;
  logic [NUM_CH-1:0]         rdl_write_r;
  logic [NUM_CH-1:0]         rdl_read_r;
  logic                      waitreq_r;
  logic                      rdatavalid_r;
  logic                      rsp_err_r;
  logic [DATA_WIDTH-1:0]     rdata_r;

  logic [AVMM_ADDR_WIDTH-1:0] addr_hi_s;
  logic [CH_W-1:0]            bank_s;
  logic                       oor_s;
  logic                       sel_valid_s;
  logic [DATA_WIDTH-1:0]      sel_data_s;

  function automatic logic [NUM_CH-1:0] bank_onehot(input logic [CH_W-1:0] bank);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      oh[i] = (bank == CH_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Bank decode of the incoming address; any bit above the bank field marks it out of range.
  always_comb begin
    addr_hi_s = i_avmm_addr >> RDL_ADDR_WIDTH;
    bank_s    = CH_W'(addr_hi_s & CH_MASK);
    oor_s     = ((addr_hi_s >> CH_BITS) != '0) || ({1'b0, bank_s} >= NUM_CH_L);
  end

  // AND-OR select of the registered bank's read return; other banks never reach the FSM.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_valid_s = sel_valid_s | ((cmd_bank_r == CH_W'(i)) & rdl_readdatavalid[i]);
      sel_data_s  = sel_data_s |
                    ({DATA_WIDTH{cmd_bank_r == CH_W'(i)}} & rdl_readdata[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Command FSM; strobes and completion outputs are registered alongside the state change.
  always_ff @(posedge avmm_clk or posedge avmm_rst) begin
    if (avmm_rst) begin
      state_r      <= ST_IDLE;
      cmd_addr_r   <= '0;
      cmd_wdata_r  <= '0;
      cmd_be_r     <= '0;
      cmd_bank_r   <= '0;
      cmd_oor_r    <= 1'b0;
      tmo_cnt_r    <= 8'd0;
      err_cnt_r    <= 8'd0;
      rdl_write_r  <= '0;
      rdl_read_r   <= '0;
      waitreq_r    <= 1'b1;
      rdatavalid_r <= 1'b0;
      rsp_err_r    <= 1'b0;
      rdata_r      <= '0;
    end else begin
      rdl_write_r  <= '0;
      rdl_read_r   <= '0;
      waitreq_r    <= 1'b1;
      rdatavalid_r <= 1'b0;
      rsp_err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_avmm_write || i_avmm_read) begin
            cmd_addr_r  <= i_avmm_addr[RDL_ADDR_WIDTH-1:0];
            cmd_wdata_r <= i_avmm_wdata;
            cmd_be_r    <= i_avmm_byte_en;
            cmd_bank_r  <= bank_s;
            cmd_oor_r   <= oor_s;
            waitreq_r   <= 1'b0;
            if (i_avmm_write) begin
              state_r     <= ST_WRITE;
              rdl_write_r <= oor_s ? '0 : bank_onehot(bank_s);
            end else begin
              state_r    <= ST_READ;
              rdl_read_r <= oor_s ? '0 : bank_onehot(bank_s);
            end
          end
        end
        ST_WRITE: begin
          state_r <= ST_IDLE;
          if (cmd_oor_r) begin
            err_cnt_r <= sat_inc(err_cnt_r);
          end
        end
        ST_READ: begin
          if (cmd_oor_r) begin
            state_r      <= ST_CPL;
            rdatavalid_r <= 1'b1;
            rdata_r      <= ERR_RDATA;
            rsp_err_r    <= 1'b1;
            err_cnt_r    <= sat_inc(err_cnt_r);
          end else if (sel_valid_s) begin
            state_r      <= ST_CPL;
            rdatavalid_r <= 1'b1;
            rdata_r      <= sel_data_s;
          end else begin
            state_r   <= ST_WAIT;
            tmo_cnt_r <= 8'd0;
          end
        end
        ST_WAIT: begin
          // A valid on the final count still wins over the timeout.
          if (sel_valid_s) begin
            state_r      <= ST_CPL;
            rdatavalid_r <= 1'b1;
            rdata_r      <= sel_data_s;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r      <= ST_CPL;
            rdatavalid_r <= 1'b1;
            rdata_r      <= ERR_RDATA;
            rsp_err_r    <= 1'b1;
            err_cnt_r    <= sat_inc(err_cnt_r);
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_CPL: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_avmm_rdata       = rdata_r;
  assign o_avmm_rdatavalid  = rdatavalid_r;
  assign o_avmm_waitrequest = waitreq_r;
  assign o_avmm_rsp_err     = rsp_err_r;
  assign o_err_cnt          = err_cnt_r;
  assign rdl_clk            = avmm_clk;
  assign rdl_reset          = avmm_rst;
  assign rdl_write          = rdl_write_r;
  assign rdl_read           = rdl_read_r;
  assign rdl_address        = cmd_addr_r;
  assign rdl_writedata      = cmd_wdata_r;
  assign rdl_byteenable     = cmd_be_r;

endmodule

// File: tb/tb_aib_avmm_rdl_mux_intf.sv
// Scoreboard bench: read completions are queued at issue and compared when rdatavalid fires.
module tb_aib_avmm_rdl_mux_intf;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic [11:0]  addr = 12'h000;
  logic [31:0]  wdata = 32'h0;
  logic [3:0]   be = 4'h0;
  logic [127:0] rd_data = 128'h0;
  logic [3:0]   rd_valid = 4'h0;
  logic [31:0]  rdata;
  logic         rdatavalid, waitreq, rsp_err;
  logic [7:0]   err_cnt;
  logic         rdl_clk, rdl_reset;
  logic [3:0]   rdl_write, rdl_read;
  logic [7:0]   rdl_address;
  logic [31:0]  rdl_writedata;
  logic [3:0]   rdl_byteenable;

  logic         rd3 = 1'b0;
  logic [11:0]  addr3 = 12'h000;
  logic [95:0]  rd_data3 = 96'h0;
  logic [2:0]   rd_valid3 = 3'b000;
  logic [31:0]  rdata3;
  logic         rdatavalid3, waitreq3, rsp_err3;
  logic [7:0]   err_cnt3;
  logic         rdl_clk3, rdl_reset3;
  logic [2:0]   rdl_write3, rdl_read3;
  logic [7:0]   rdl_address3;
  logic [31:0]  rdl_writedata3;
  logic [3:0]   rdl_byteenable3;

  int          checks = 0;
  int          errors = 0;
  int          done_cyc;
  logic [32:0] exp_q[$];
  logic [32:0] exp3_q[$];
  logic [32:0] exp_e;
  logic [32:0] exp3_e;

  aib_avmm_rdl_mux_intf dut (
    .avmm_clk(clk), .avmm_rst(rst),
    .i_avmm_write(wr), .i_avmm_read(rd), .i_avmm_addr(addr),
    .i_avmm_wdata(wdata), .i_avmm_byte_en(be),
    .o_avmm_rdata(rdata), .o_avmm_rdatavalid(rdatavalid),
    .o_avmm_waitrequest(waitreq), .o_avmm_rsp_err(rsp_err), .o_err_cnt(err_cnt),
    .rdl_clk(rdl_clk), .rdl_reset(rdl_reset), .rdl_write(rdl_write), .rdl_read(rdl_read),
    .rdl_address(rdl_address), .rdl_writedata(rdl_writedata), .rdl_byteenable(rdl_byteenable),
    .rdl_readdata(rd_data), .rdl_readdatavalid(rd_valid)
  );

  aib_avmm_rdl_mux_intf #(.NUM_CH(3)) dut3 (
    .avmm_clk(clk), .avmm_rst(rst),
    .i_avmm_write(1'b0), .i_avmm_read(rd3), .i_avmm_addr(addr3),
    .i_avmm_wdata(32'h0), .i_avmm_byte_en(4'h0),
    .o_avmm_rdata(rdata3), .o_avmm_rdatavalid(rdatavalid3),
    .o_avmm_waitrequest(waitreq3), .o_avmm_rsp_err(rsp_err3), .o_err_cnt(err_cnt3),
    .rdl_clk(rdl_clk3), .rdl_reset(rdl_reset3), .rdl_write(rdl_write3), .rdl_read(rdl_read3),
    .rdl_address(rdl_address3), .rdl_writedata(rdl_writedata3), .rdl_byteenable(rdl_byteenable3),
    .rdl_readdata(rd_data3), .rdl_readdatavalid(rd_valid3)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 4-bank instance.
  always @(negedge clk) begin
    if (rdatavalid) begin
      check_val("cpl_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check_val("cpl_rdata", 64'(rdata), 64'(exp_e[31:0]));
        check_val("cpl_err", 64'(rsp_err), 64'(exp_e[32]));
      end
    end
  end

  // Scoreboard for the 3-bank instance.
  always @(negedge clk) begin
    if (rdatavalid3) begin
      check_val("cpl3_pending", 64'(exp3_q.size() != 0), 64'd1);
      if (exp3_q.size() != 0) begin
        exp3_e = exp3_q.pop_front();
        check_val("cpl3_rdata", 64'(rdata3), 64'(exp3_e[31:0]));
        check_val("cpl3_err", 64'(rsp_err3), 64'(exp3_e[32]));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check_val("rst_waitreq", 64'(waitreq), 64'd1);
    check_val("rst_rdatavalid", 64'(rdatavalid), 64'd0);
    check_val("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_val("rst_rdata", 64'(rdata), 64'd0);
    check_val("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_val("rst_strobes", 64'({rdl_write, rdl_read}), 64'd0);
    check_val("rst_rdl_reset", 64'(rdl_reset), 64'd1);
    rst = 1'b0;
    step();

    // Write 0x1A4 -> bank 1, offset 0xA4
    wr = 1'b1; addr = 12'h1A4; wdata = 32'hDEADBEEF; be = 4'hF;
    check_val("wr_c0_waitreq", 64'(waitreq), 64'd1);
    step();
    check_val("wr_c1_strobe", 64'(rdl_write), 64'h2);
    check_val("wr_c1_addr", 64'(rdl_address), 64'hA4);
    check_val("wr_c1_wdata", 64'(rdl_writedata), 64'hDEADBEEF);
    check_val("wr_c1_be", 64'(rdl_byteenable), 64'hF);
    check_val("wr_c1_waitreq", 64'(waitreq), 64'd0);
    check_val("wr_c1_read", 64'(rdl_read), 64'd0);
    wr = 1'b0;
    step();
    check_val("wr_c2_waitreq", 64'(waitreq), 64'd1);
    check_val("wr_c2_strobe", 64'(rdl_write), 64'd0);
    check_val("wr_no_cpl", 64'(rdatavalid), 64'd0);

    // Read 0x305 -> bank 3, valid two cycles after the strobe
    rd = 1'b1; addr = 12'h305;
    exp_q.push_back({1'b0, 32'h12345678});
    step();
    check_val("rd_c1_strobe", 64'(rdl_read), 64'h8);
    check_val("rd_c1_addr", 64'(rdl_address), 64'h05);
    check_val("rd_c1_waitreq", 64'(waitreq), 64'd0);
    rd = 1'b0;
    step();
    rd_valid = 4'b0001; rd_data[31:0] = 32'h0BAD0BAD;
    step();
    rd_valid = 4'b1000; rd_data[127:96] = 32'h12345678;
    check_val("rd_c3_no_cpl", 64'(rdatavalid), 64'd0);
    step();
    rd_valid = 4'b0000;
    check_val("rd_c4_cpl", 64'(rdatavalid), 64'd1);
    step();
    check_val("rd_c5_one_pulse", 64'(rdatavalid), 64'd0);
    check_val("rd_c5_err_low", 64'(rsp_err), 64'd0);

    // Read bank 0 with valid already present in the strobe cycle
    rd = 1'b1; addr = 12'h010;
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    step();
    rd = 1'b0;
    check_val("rd0_strobe", 64'(rdl_read), 64'h1);
    rd_valid = 4'b0001; rd_data[31:0] = 32'hCAFEF00D;
    step();
    rd_valid = 4'b0000;
    check_val("rd0_cpl_k1", 64'(rdatavalid), 64'd1);
    step();
    check_val("rd0_rdata_hold", 64'(rdata), 64'hCAFEF00D);

    // Out-of-range read via an address bit above the bank field
    rd = 1'b1; addr = 12'h400;
    exp_q.push_back({1'b1, 32'hFFFFFFFF});
    step();
    rd = 1'b0;
    check_val("oor_rd_no_strobe", 64'(rdl_read), 64'd0);
    step();
    check_val("oor_rd_cpl", 64'(rdatavalid), 64'd1);
    check_val("oor_rd_err_cnt", 64'(err_cnt), 64'd1);
    step();

    // Timeout on bank 0; a bank-1 valid in WAIT must be ignored
    rd = 1'b1; addr = 12'h020;
    exp_q.push_back({1'b1, 32'hFFFFFFFF});
    done_cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i == 1) rd = 1'b0;
      if (i == 5) begin rd_valid = 4'b0010; rd_data[63:32] = 32'h11111111; end
      if (i == 6) rd_valid = 4'b0000;
      if (rdatavalid) begin
        done_cyc = i;
        break;
      end
    end
    check_val("tmo_latency", 64'(done_cyc), 64'd66);
    check_val("tmo_err_cnt", 64'(err_cnt), 64'd2);
    step();

    // Write and read together: write first, read after returning to IDLE
    wr = 1'b1; rd = 1'b1; addr = 12'h2B0; wdata = 32'h0F0F0F0F; be = 4'h3;
    exp_q.push_back({1'b0, 32'h5555AAAA});
    step();
    check_val("both_write_first", 64'(rdl_write), 64'h4);
    check_val("both_no_read_yet", 64'(rdl_read), 64'd0);
    wr = 1'b0;
    step();
    check_val("both_idle_waitreq", 64'(waitreq), 64'd1);
    step();
    check_val("both_read_strobe", 64'(rdl_read), 64'h4);
    rd = 1'b0;
    rd_valid = 4'b0100; rd_data[95:64] = 32'h5555AAAA;
    step();
    rd_valid = 4'b0000;
    check_val("both_read_cpl", 64'(rdatavalid), 64'd1);
    step();

    // NUM_CH=3 instance: bank 3 does not exist
    rd3 = 1'b1; addr3 = 12'h300;
    exp3_q.push_back({1'b1, 32'hFFFFFFFF});
    step();
    rd3 = 1'b0;
    check_val("ch3_no_strobe", 64'(rdl_read3), 64'd0);
    step();
    check_val("ch3_cpl", 64'(rdatavalid3), 64'd1);
    check_val("ch3_err_cnt", 64'(err_cnt3), 64'd1);
    step();

    // 300 out-of-range writes saturate the error counter
    for (int n = 0; n < 300; n++) begin
      wr = 1'b1; addr = 12'h800;
      step();
      wr = 1'b0;
      if (n == 0) check_val("oor_wr_no_strobe", 64'(rdl_write), 64'd0);
      step();
      if (n == 0) check_val("oor_wr_err_cnt", 64'(err_cnt), 64'd3);
    end
    step();
    check_val("err_cnt_sat", 64'(err_cnt), 64'd255);

    // Reset during WAIT aborts the read with no completion
    rd = 1'b1; addr = 12'h100;
    step();
    rd = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_val("midrst_waitreq", 64'(waitreq), 64'd1);
    check_val("midrst_strobes", 64'({rdl_write, rdl_read}), 64'd0);
    check_val("midrst_rdatavalid", 64'(rdatavalid), 64'd0);
    check_val("midrst_rdata", 64'(rdata), 64'd0);
    check_val("midrst_err_cnt", 64'(err_cnt), 64'd0);
    step();
    rst = 1'b0;
    rd_valid = 4'b0010; rd_data[63:32] = 32'h22222222;
    step();
    rd_valid = 4'b0000;
    repeat (5) step();
    check_val("post_rst_no_cpl", 64'(rdatavalid), 64'd0);

    check_val("queues_drained", 64'(exp_q.size() + exp3_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aib_avmm_rdl_mux_intf.md
AIB_AVMM_RDL_MUX_INTF -- requirements
Module: aib_avmm_rdl_mux_intf

Interface
REQ-001 The parameter AVMM_ADDR_WIDTH SHALL default to 12 and set the AVMM slave address width.
REQ-002 The parameter RDL_ADDR_WIDTH SHALL default to 8 and set the per-bank RDL address width.
REQ-003 The parameter NUM_CH SHALL default to 4 (range 1..16) and set the number of RDL register banks.
REQ-004 The parameter DATA_WIDTH SHALL default to 32 (32 or 64) and set the data width; BE_WIDTH = DATA_WIDTH/8.
REQ-005 The parameter TIMEOUT_CYC SHALL default to 64 (range 2..255) and set the read-completion timeout in cycles.
REQ-006 The parameter ERR_RDATA SHALL default to all-ones and set the data returned on error.
REQ-007 Ports SHALL be:
  avmm_clk  in  1  single clock for all logic
  avmm_rst  in  1  asynchronous, active-high reset
  i_avmm_write  in  1  write request
  i_avmm_read  in  1  read request
  i_avmm_addr  in  AVMM_ADDR_WIDTH  word address
  i_avmm_wdata  in  DATA_WIDTH  write data
  i_avmm_byte_en  in  BE_WIDTH  byte enables
  o_avmm_rdata  out  DATA_WIDTH  read data, registered
  o_avmm_rdatavalid  out  1  read completion strobe
  o_avmm_waitrequest  out  1  slave stall
  o_avmm_rsp_err  out  1  error flag, qualified by o_avmm_rdatavalid
  o_err_cnt  out  8  saturating error counter
  rdl_clk  out  1  equals avmm_clk
  rdl_reset  out  1  equals avmm_rst
  rdl_write  out  NUM_CH  per-bank write strobe
  rdl_read  out  NUM_CH  per-bank read strobe
  rdl_address  out  RDL_ADDR_WIDTH  shared bank address
  rdl_writedata  out  DATA_WIDTH  shared write data
  rdl_byteenable  out  BE_WIDTH  shared byte enables
  rdl_readdata  in  NUM_CH*DATA_WIDTH  bank n at [n*DATA_WIDTH +: DATA_WIDTH]
  rdl_readdatavalid  in  NUM_CH  per-bank read valid
REQ-008 AVMM_ADDR_WIDTH SHALL be >= RDL_ADDR_WIDTH + CH_BITS, CH_BITS = clog2(NUM_CH) (0 when NUM_CH=1); violation is an elaboration error.

Function
REQ-009 Decode: bank = addr[RDL_ADDR_WIDTH +: CH_BITS]; out-of-range (OOR) when bank >= NUM_CH or any address bit above RDL_ADDR_WIDTH+CH_BITS is nonzero.
REQ-010 FSM states SHALL be IDLE, WRITE, READ, WAIT, CPL; undefined encodings go to IDLE.
REQ-011 o_avmm_waitrequest SHALL be 0 only in WRITE and READ, 1 in all other states.
REQ-012 IDLE: on i_avmm_write -> WRITE; else on i_avmm_read -> READ; write wins when both are asserted; address, wdata, byte_en, bank and OOR are registered on this transition.
REQ-013 WRITE (one cycle): rdl_write[bank]=1 from registered command unless OOR (then none asserted, o_err_cnt increments) -> IDLE; no completion is generated.
REQ-014 READ (one cycle): rdl_read[bank]=1 unless OOR; OOR -> CPL with error; selected valid high this cycle -> capture, CPL; else -> WAIT with timeout counter cleared.
REQ-015 WAIT: counter increments each cycle; selected rdl_readdatavalid captures rdl_readdata slice -> CPL, no error; counter reaching TIMEOUT_CYC-1 without valid -> CPL with error.
REQ-016 CPL (one cycle): o_avmm_rdatavalid=1; o_avmm_rdata = captured data or ERR_RDATA on error; o_avmm_rsp_err=1 on error -> IDLE.
REQ-017 o_avmm_rdata SHALL hold its last value outside CPL; o_avmm_rsp_err SHALL be 0 outside CPL.
REQ-018 rdl_readdatavalid from non-selected banks, or in IDLE/WRITE/CPL, SHALL be ignored.
REQ-019 Write latency: request in cycle 0 -> waitrequest low and strobe in cycle 1; read valid in cycle k>=1 -> rdatavalid in k+1.
REQ-020 o_err_cnt SHALL increment once per OOR access or timeout and saturate at 255.
REQ-021 rdl_address, rdl_writedata, rdl_byteenable SHALL be driven from the registered command.

Reset
REQ-022 avmm_rst high SHALL asynchronously force IDLE, all strobes 0, o_avmm_waitrequest 1, o_avmm_rdatavalid 0, o_avmm_rsp_err 0, o_avmm_rdata 0, o_err_cnt 0, timeout counter 0, command registers 0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no completion; post-reset late readdatavalid is ignored.

Verification
REQ-024 Write 0x1A4, wdata 0xDEADBEEF, be 0xF -> rdl_write=4'b0010, rdl_address 0xA4 in cycle 1, waitrequest low only in cycle 1.
REQ-025 Read 0x305, bank 3 valid 2 cycles after strobe with 0x12345678 -> rdatavalid 1 cycle, rdata 0x12345678, rsp_err 0.
REQ-026 NUM_CH=3, read 0x300 -> no rdl_read, rdatavalid with rdata 0xFFFFFFFF, rsp_err 1, o_err_cnt 1.
REQ-027 Read bank 0, valid never returns -> completion TIMEOUT_CYC+2 cycles after request, rsp_err 1; bank-1 valid during WAIT ignored.
REQ-028 Write and read asserted together -> write performed first, read serviced after return to IDLE; 300 OOR writes -> o_err_cnt 255.
REQ-029 avmm_rst pulsed in WAIT -> all outputs at reset values immediately, no rdatavalid afterward.
